// File: rtl/fetch_pkg.sv
// Shared widths, reset/halt constants and the fetch FSM state encoding.
// STEP is always declared so the encoding is identical with or without FETCH_STEP_EN.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 8'h00;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT,
        STEP
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: load has priority over increment, and increment wraps modulo 2**PC_W.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational next-state uses blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: PC, ROM address, instruction register and valid/ready issue.
// Optional single-step mode is enabled by defining FETCH_STEP_EN (adds the step input and STEP state).
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_addr,
`ifdef FETCH_STEP_EN
    input  logic               step,
`endif
    output logic               halted
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc;
    logic               pc_load;
    logic [PC_W-1:0]    pc_load_val;
    logic               pc_inc;
    logic               capture;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    instr_pc_q;
    logic               valid_q;
    logic               halted_q;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pc_load     = 1'b0;
        pc_load_val = RESET_PC;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // A redirect discards whatever the ROM returned, even a halt word.
                if (jump) begin
                    pc_load     = 1'b1;
                    pc_load_val = jump_addr;
                end else if (rom_data == HALT_WORD) begin
                    state_d = HALT;
                end else begin
                    capture = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (jump) begin
                    pc_load     = 1'b1;
                    pc_load_val = jump_addr;
                    state_d     = FETCH;
                end else if (instr_ready) begin
`ifdef FETCH_STEP_EN
                    state_d = STEP;
`else
                    state_d = FETCH;
`endif
                end
            end
            HALT: begin
                if (start) begin
                    pc_load = 1'b1;
                    state_d = FETCH;
                end
            end
`ifdef FETCH_STEP_EN
            STEP: begin
                if (jump) begin
                    pc_load     = 1'b1;
                    pc_load_val = jump_addr;
                end else if (step) begin
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= (state_d == ISSUE);
            halted_q <= (state_d == HALT);
            if (capture) begin
                instr_q    <= rom_data;
                instr_pc_q <= pc;
            end
        end
    end

    assign rom_addr    = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus pushes expected transfers, a monitor pops them.
// Covers reset, streaming, stall, jump flush, pc wrap, halt/restart, async reset and (optionally) step mode.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        halted;
`ifdef FETCH_STEP_EN
    logic        step;
`endif

    logic [15:0] rom [256];
    exp_t        sb [$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;

    assign rom_data = rom[rom_addr];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .jump_addr   (jump_addr),
`ifdef FETCH_STEP_EN
        .step        (step),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] i, input logic [7:0] p);
        exp_t e;
        e.instr = i;
        e.pc    = p;
        sb.push_back(e);
    endtask

    // A transfer happens at the next rising edge when valid & ready and no jump flushes it.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready && !jump) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_transfer: got instr %0h pc %0h, required no transfer", instr, instr_pc);
            end else begin
                mon_e = sb.pop_front();
                check("xfer_instr", {16'h0, instr}, {16'h0, mon_e.instr});
                check("xfer_pc", {24'h0, instr_pc}, {24'h0, mon_e.pc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'hA0, 8'(i)};
        rom[0]     = 16'h1000;
        rom[1]     = 16'h1001;
        rom[2]     = 16'h1002;
        rom[3]     = 16'hFFFF;
        rom[8'hFE] = 16'h20FE;
        rom[8'hFF] = 16'h20FF;

        reset       = 1'b1;
        start       = 1'b0;
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_addr   = 8'h00;
`ifdef FETCH_STEP_EN
        step        = 1'b0;
`endif
        tick();
        tick();
        check("rst_rom_addr", {24'h0, rom_addr}, 32'h00);
        check("rst_instr", {16'h0, instr}, 32'h0000);
        check("rst_instr_pc", {24'h0, instr_pc}, 32'h00);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        reset = 1'b0;
        tick();

        // Streaming: three instructions at one per two cycles, then halt word at address 3.
        push(16'h1000, 8'h00);
        push(16'h1001, 8'h01);
        push(16'h1002, 8'h02);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_fetch_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("lat_issue_valid", {31'h0, instr_valid}, 32'h1);
        n = 2;
        while (!halted && n < 50) begin
            tick();
            n++;
        end
        check("halt_cycles", n, 8);
        check("halted", {31'h0, halted}, 32'h1);
        check("halt_pc", {24'h0, rom_addr}, 32'h03);
        check("halt_no_valid", {31'h0, instr_valid}, 32'h0);
        check("stream_drained", sb.size(), 0);

        // Jump while halted is ignored.
        jump = 1'b1;
        jump_addr = 8'h80;
        tick();
        jump = 1'b0;
        check("halt_jump_halted", {31'h0, halted}, 32'h1);
        check("halt_jump_pc", {24'h0, rom_addr}, 32'h03);

        // Restart and stall for five cycles.
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", {24'h0, rom_addr}, 32'h00);
        check("restart_halted", {31'h0, halted}, 32'h0);
        tick();
        check("stall_valid0", {31'h0, instr_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'h0, instr_valid}, 32'h1);
            check("stall_instr", {16'h0, instr}, 32'h1000);
            check("stall_pc", {24'h0, instr_pc}, 32'h00);
        end
        push(16'h1000, 8'h00);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("post_xfer_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("next_fetch_pc", {24'h0, instr_pc}, 32'h01);
        check("next_fetch_instr", {16'h0, instr}, 32'h1001);

        // Jump together with ready: the pending instruction is flushed.
        instr_ready = 1'b1;
        jump = 1'b1;
        jump_addr = 8'h40;
        tick();
        jump = 1'b0;
        instr_ready = 1'b0;
        check("flush_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("jump_valid", {31'h0, instr_valid}, 32'h1);
        check("jump_instr_pc", {24'h0, instr_pc}, 32'h40);
        check("jump_instr", {16'h0, instr}, 32'hA040);
        push(16'hA040, 8'h40);
        instr_ready = 1'b1;
        tick();

        // Jump during FETCH, then run across the 0xFF -> 0x00 wrap into the halt word.
        instr_ready = 1'b0;
        jump = 1'b1;
        jump_addr = 8'hFE;
        tick();
        jump = 1'b0;
        check("fetch_jump_pc", {24'h0, rom_addr}, 32'hFE);
        check("fetch_jump_valid", {31'h0, instr_valid}, 32'h0);
        push(16'h20FE, 8'hFE);
        push(16'h20FF, 8'hFF);
        push(16'h1000, 8'h00);
        push(16'h1001, 8'h01);
        push(16'h1002, 8'h02);
        instr_ready = 1'b1;
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        check("wrap_halted", {31'h0, halted}, 32'h1);
        check("wrap_drained", sb.size(), 0);

        // Asynchronous reset while an instruction is offered.
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_valid", {31'h0, instr_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", {31'h0, instr_valid}, 32'h0);
        check("areset_instr", {16'h0, instr}, 32'h0000);
        check("areset_rom_addr", {24'h0, rom_addr}, 32'h00);
        check("areset_halted", {31'h0, halted}, 32'h0);
        tick();
        reset = 1'b0;

        // Jump in IDLE is ignored.
        jump = 1'b1;
        jump_addr = 8'h55;
        tick();
        jump = 1'b0;
        tick();
        check("idle_jump_pc", {24'h0, rom_addr}, 32'h00);
        check("idle_valid", {31'h0, instr_valid}, 32'h0);

`ifdef FETCH_STEP_EN
        // Step mode: no fetch after a handshake until step is pulsed.
        push(16'h1000, 8'h00);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("step_wait_valid", {31'h0, instr_valid}, 32'h0);
        end
        check("step_wait_pc", {24'h0, rom_addr}, 32'h01);
        push(16'h1001, 8'h01);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch_valid", {31'h0, instr_valid}, 32'h0);
        tick();
        check("step_issue_valid", {31'h0, instr_valid}, 32'h1);
        check("step_issue_pc", {24'h0, instr_pc}, 32'h01);
`endif

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
